// File: rtl/axi_cmd_pkg.sv
// Shared types and constants for the single-outstanding AXI command master.
// Holds the FSM state encodings, AXI burst/response codes and the response-merge rule.
package axi_cmd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_AW   = 3'd1;
    localparam state_t S_W    = 3'd2;
    localparam state_t S_B    = 3'd3;
    localparam state_t S_AR   = 3'd4;
    localparam state_t S_R    = 3'd5;
    localparam state_t S_DONE = 3'd6;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Numerically larger response wins, so DECERR > SLVERR > OKAY.
    function automatic logic [1:0] resp_merge(input logic [1:0] acc, input logic [1:0] nxt);
        return (nxt > acc) ? nxt : acc;
    endfunction

endpackage

// File: rtl/axi_cmd_master_if.sv
// AXI4 AW/W/B/AR/R channel bundle between the command master and its slave (e.g. axi2ram).
interface axi_cmd_master_if #(
    parameter int IDWID = 4,
    parameter int DWID  = 64
) ();
    localparam int WSTRB = DWID / 8;

    logic [31:0]      awaddr;
    logic [1:0]       awburst;
    logic [IDWID-1:0] awid;
    logic [7:0]       awlen;
    logic             awvalid;
    logic             awready;

    logic [DWID-1:0]  wdata;
    logic [WSTRB-1:0] wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready;

    logic [IDWID-1:0] bid;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;

    logic [31:0]      araddr;
    logic [1:0]       arburst;
    logic [IDWID-1:0] arid;
    logic [7:0]       arlen;
    logic             arvalid;
    logic             arready;

    logic [DWID-1:0]  rdata;
    logic [IDWID-1:0] rid;
    logic             rlast;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready;

    modport master (
        output awaddr, awburst, awid, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arburst, arid, arlen, arvalid,
        input  arready,
        input  rdata, rid, rlast, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awburst, awid, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arburst, arid, arlen, arvalid,
        output arready,
        output rdata, rid, rlast, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI master: one command -> one INCR burst -> one completion pulse.
// Optional AXI_4K_CHECK_EN: bursts crossing a 4 KiB boundary complete with SLVERR without AXI traffic.
module axi_cmd_master
    import axi_cmd_pkg::*;
#(
    parameter int IDWID = 4,
    parameter int DWID  = 64
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [7:0]       cmd_len,
    input  logic [IDWID-1:0] cmd_id,

    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DWID-1:0]  wr_data,

    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DWID-1:0]  rd_data,
    output logic             rd_last,

    output logic             done_valid,
    output logic             done_write,
    output logic [IDWID-1:0] done_id,
    output logic [1:0]       done_resp,

    axi_cmd_master_if.master axi
);

    state_t           state_q, state_d;
    logic [31:0]      addr_q,  addr_d;
    logic [7:0]       len_q,   len_d;
    logic [IDWID-1:0] id_q,    id_d;
    logic             write_q, write_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic [1:0]       resp_q,  resp_d;
    logic [1:0]       resp_tmp;

`ifdef AXI_4K_CHECK_EN
    logic [13:0] end_off;
    logic        cross_4k;
    assign end_off  = 14'(cmd_addr[11:0]) + ((14'(cmd_len) + 14'd1) << 3);
    assign cross_4k = end_off > 14'd4096;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        id_d     = id_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        resp_d   = resp_q;
        resp_tmp = resp_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    write_d = cmd_write;
                    cnt_d   = cmd_len;
                    resp_d  = RESP_OKAY;
`ifdef AXI_4K_CHECK_EN
                    if (cross_4k) begin
                        resp_d  = RESP_SLVERR;
                        state_d = S_DONE;
                    end else
`endif
                    state_d = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: if (axi.awready) state_d = S_W;
            S_W: begin
                if (wr_valid && axi.wready) begin
                    if (cnt_q == 8'd0) state_d = S_B;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            S_B: begin
                if (axi.bvalid) begin
                    resp_tmp = resp_merge(resp_q, axi.bresp);
                    if (axi.bid != id_q) resp_tmp = resp_merge(resp_tmp, RESP_SLVERR);
                    resp_d  = resp_tmp;
                    state_d = S_DONE;
                end
            end
            S_AR: if (axi.arready) state_d = S_R;
            S_R: begin
                if (axi.rvalid && rd_ready) begin
                    resp_tmp = resp_merge(resp_q, axi.rresp);
                    if (axi.rid != id_q) resp_tmp = resp_merge(resp_tmp, RESP_SLVERR);
                    // Short burst (early rlast) and overrun (no rlast at count 0) are both SLVERR.
                    if (axi.rlast) begin
                        if (cnt_q != 8'd0) resp_tmp = resp_merge(resp_tmp, RESP_SLVERR);
                        state_d = S_DONE;
                    end else if (cnt_q == 8'd0) begin
                        resp_tmp = resp_merge(resp_tmp, RESP_SLVERR);
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    resp_d = resp_tmp;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // rst_n gates cmd_ready so no command is taken while reset is held.
    assign cmd_ready   = rst_n && (state_q == S_IDLE);

    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awid    = id_q;
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = (state_q == S_AW);

    assign axi.wvalid  = (state_q == S_W) && wr_valid;
    assign axi.wdata   = wr_data;
    assign axi.wstrb   = '1;
    assign axi.wlast   = (state_q == S_W) && (cnt_q == 8'd0);
    assign wr_ready    = (state_q == S_W) && axi.wready;

    assign axi.bready  = (state_q == S_B);

    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arid    = id_q;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = (state_q == S_AR);

    assign axi.rready  = (state_q == S_R) && rd_ready;
    assign rd_valid    = (state_q == S_R) && axi.rvalid;
    assign rd_data     = axi.rdata;
    assign rd_last     = (state_q == S_R) && axi.rlast;

    assign done_valid  = (state_q == S_DONE);
    assign done_write  = write_q;
    assign done_id     = id_q;
    assign done_resp   = resp_q;

endmodule
